// File: rtl/engine_start_ctrl.sv
// rtl/engine_start_ctrl.sv - ignition sequencer: OFF -> CRANK -> RUN with interlocks and fault shutdown
module engine_start_ctrl #(
  parameter logic [7:0] CRANK_TICKS   = 8'd20,
  parameter logic [7:0] TEMP_LIMIT    = 8'd180,
  parameter logic [7:0] TEMP_RESUME   = 8'd120,
  parameter logic [7:0] OVERHEAT_SECS = 8'd5,
  parameter logic [7:0] KILL_SECS     = 8'd3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1sec,
  input  logic       tick_speed,
  input  logic       btn_start,
  input  logic       is_brake_normal,
  input  logic [3:0] current_gear,
  input  logic [7:0] speed,
  input  logic [7:0] fuel,
  input  logic [7:0] temp,
  output logic       engine_on,
  output logic       cranking,
  output logic [2:0] state,
  output logic [1:0] fault_code,
  output logic       start_denied
);

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_CRANK = 3'd1,
    S_RUN   = 3'd2,
    S_FAULT = 3'd3
  } state_t;

  state_t     r_state;
  logic       r_sync1;
  logic       r_sync2;
  logic       r_hist;
  logic       r_engine_on;
  logic       r_cranking;
  logic [1:0] r_fault_code;
  logic       r_start_denied;
  logic [7:0] r_crank_cnt;
  logic [7:0] r_oh_cnt;
  logic [7:0] r_kill_cnt;

  logic       w_press;
  logic       w_held;
  logic       w_gear_pn;
  logic       w_fuel_ok;
  logic       w_hot;
  logic       w_start_ok;
  logic       w_cause_clear;
  logic [7:0] w_crank_inc;
  logic [7:0] w_oh_inc;
  logic [7:0] w_kill_inc;

  assign w_press    = r_sync2 & ~r_hist;
  assign w_held     = r_sync2;
  assign w_gear_pn  = (current_gear == 4'd3) || (current_gear == 4'd9);
  assign w_fuel_ok  = (fuel != 8'd0);
  assign w_hot      = (temp >= TEMP_LIMIT);
  assign w_start_ok = is_brake_normal & w_gear_pn & w_fuel_ok & ~w_hot;

  // Codes 0/1 cannot occur in FAULT; treat them as already cleared so the FSM never sticks.
  assign w_cause_clear = ((r_fault_code == 2'd2) && w_fuel_ok) ||
                         ((r_fault_code == 2'd3) && (temp < TEMP_RESUME)) ||
                         (r_fault_code < 2'd2);

  assign w_crank_inc = (r_crank_cnt == 8'hFF) ? r_crank_cnt : r_crank_cnt + 8'd1;
  assign w_oh_inc    = (r_oh_cnt    == 8'hFF) ? r_oh_cnt    : r_oh_cnt    + 8'd1;
  assign w_kill_inc  = (r_kill_cnt  == 8'hFF) ? r_kill_cnt  : r_kill_cnt  + 8'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= S_OFF;
      r_sync1        <= 1'b0;
      r_sync2        <= 1'b0;
      r_hist         <= 1'b0;
      r_engine_on    <= 1'b0;
      r_cranking     <= 1'b0;
      r_fault_code   <= 2'd0;
      r_start_denied <= 1'b0;
      r_crank_cnt    <= 8'd0;
      r_oh_cnt       <= 8'd0;
      r_kill_cnt     <= 8'd0;
    end else begin
      r_sync1        <= btn_start;
      r_sync2        <= r_sync1;
      r_hist         <= r_sync2;
      r_start_denied <= 1'b0;

      case (r_state)
        S_OFF: begin
          r_engine_on <= 1'b0;
          r_cranking  <= 1'b0;
          r_crank_cnt <= 8'd0;
          r_oh_cnt    <= 8'd0;
          r_kill_cnt  <= 8'd0;
          if (w_press) begin
            if (w_start_ok) begin
              r_state      <= S_CRANK;
              r_cranking   <= 1'b1;
              r_fault_code <= 2'd0;
            end else begin
              r_start_denied <= 1'b1;
              if (!w_fuel_ok)  r_fault_code <= 2'd2;
              else if (w_hot)  r_fault_code <= 2'd3;
              else             r_fault_code <= 2'd1;
            end
          end
        end

        S_CRANK: begin
          r_engine_on <= 1'b0;
          r_cranking  <= 1'b1;
          // Interlock abort outranks crank completion in the same cycle.
          if (!is_brake_normal || !w_gear_pn) begin
            r_state      <= S_OFF;
            r_cranking   <= 1'b0;
            r_fault_code <= 2'd1;
            r_crank_cnt  <= 8'd0;
          end else if (tick_speed) begin
            if (w_crank_inc >= CRANK_TICKS) begin
              r_state     <= S_RUN;
              r_engine_on <= 1'b1;
              r_cranking  <= 1'b0;
              r_crank_cnt <= 8'd0;
            end else begin
              r_crank_cnt <= w_crank_inc;
            end
          end
        end

        S_RUN: begin
          r_engine_on <= 1'b1;
          r_cranking  <= 1'b0;
          if (!w_fuel_ok) begin
            r_state      <= S_FAULT;
            r_engine_on  <= 1'b0;
            r_fault_code <= 2'd2;
            r_oh_cnt     <= 8'd0;
            r_kill_cnt   <= 8'd0;
          end else if (tick_1sec && w_hot && (w_oh_inc >= OVERHEAT_SECS)) begin
            r_state      <= S_FAULT;
            r_engine_on  <= 1'b0;
            r_fault_code <= 2'd3;
            r_oh_cnt     <= 8'd0;
            r_kill_cnt   <= 8'd0;
          end else begin
            if (tick_1sec) r_oh_cnt <= w_hot ? w_oh_inc : 8'd0;
            if (w_press) begin
              if ((speed == 8'd0) && w_gear_pn) begin
                r_state      <= S_OFF;
                r_engine_on  <= 1'b0;
                r_fault_code <= 2'd0;
                r_oh_cnt     <= 8'd0;
                r_kill_cnt   <= 8'd0;
              end else begin
                r_start_denied <= 1'b1;
              end
            end else if (!w_held) begin
              r_kill_cnt <= 8'd0;
            end else if (tick_1sec && (speed != 8'd0)) begin
              if (w_kill_inc >= KILL_SECS) begin
                r_state      <= S_OFF;
                r_engine_on  <= 1'b0;
                r_fault_code <= 2'd0;
                r_oh_cnt     <= 8'd0;
                r_kill_cnt   <= 8'd0;
              end else begin
                r_kill_cnt <= w_kill_inc;
              end
            end
          end
        end

        S_FAULT: begin
          r_engine_on <= 1'b0;
          r_cranking  <= 1'b0;
          r_crank_cnt <= 8'd0;
          r_oh_cnt    <= 8'd0;
          r_kill_cnt  <= 8'd0;
          if (w_press) r_start_denied <= 1'b1;
          if (tick_1sec && w_cause_clear) r_state <= S_OFF;
        end

        default: begin
          r_state     <= S_OFF;
          r_engine_on <= 1'b0;
          r_cranking  <= 1'b0;
          r_crank_cnt <= 8'd0;
          r_oh_cnt    <= 8'd0;
          r_kill_cnt  <= 8'd0;
        end
      endcase
    end
  end

  assign engine_on    = r_engine_on;
  assign cranking     = r_cranking;
  assign state        = r_state;
  assign fault_code   = r_fault_code;
  assign start_denied = r_start_denied;

endmodule
